// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Brief    : Mode-0 (CPOL=0, CPHA=0) SPI initiator. Accepts a parallel word
//             on a start strobe, shifts it out MSB first on mosi while
//             capturing miso, and returns the received word with a one-cycle
//             ack. sck half-period is CLK_DIV system clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ds,
  output logic [DATA_W-1:0] dr,
  output logic              ack,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs
);

  // Divider counts 0..CLK_DIV-1; bit counter counts completed sck falls.
  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t            state,   state_d;
  logic [CNT_W-1:0]  div_cnt, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr,   tx_sr_d;
  logic [DATA_W-1:0] rx_sr,   rx_sr_d;
  logic [DATA_W-1:0] dr_d;
  logic              sck_d, cs_d, mosi_d, busy_d, ack_d;

  // One half-period of sck has elapsed on this clk edge.
  logic              div_tick;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  assign div_tick = (div_cnt == DIV_LAST);

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_d   = state;
    div_cnt_d = div_cnt;
    bit_cnt_d = bit_cnt;
    tx_sr_d   = tx_sr;
    rx_sr_d   = rx_sr;
    dr_d      = dr;
    sck_d     = sck;
    cs_d      = cs;
    mosi_d    = mosi;
    busy_d    = busy;
    ack_d     = 1'b0;

    // Shifted views built without slicing so DATA_W=1 stays legal.
    tx_shift    = tx_sr << 1;
    rx_shift    = rx_sr << 1;
    rx_shift[0] = miso;

    // The divider free-runs whenever a transfer is active.
    if (state != IDLE) begin
      div_cnt_d = div_tick ? '0 : div_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        sck_d     = 1'b0;
        cs_d      = 1'b1;
        mosi_d    = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          tx_sr_d = ds;
          mosi_d  = ds[DATA_W-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = LEAD;
        end
      end

      // cs-to-first-edge setup; the first sck rise also samples miso.
      LEAD: begin
        if (div_tick) begin
          sck_d   = 1'b1;
          rx_sr_d = rx_shift;
          state_d = XFER;
        end
      end

      XFER: begin
        if (div_tick) begin
          if (sck) begin
            sck_d = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              // Final fall: mosi keeps bit 0 through the trail period.
              bit_cnt_d = '0;
              state_d   = TRAIL;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
              tx_sr_d   = tx_shift;
              mosi_d    = tx_shift[DATA_W-1];
            end
          end else begin
            sck_d   = 1'b1;
            rx_sr_d = rx_shift;
          end
        end
      end

      // Hold time after the last fall, then release cs and publish dr.
      TRAIL: begin
        if (div_tick) begin
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          dr_d    = rx_sr;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      dr      <= '0;
      sck     <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
    end else begin
      state   <= state_d;
      div_cnt <= div_cnt_d;
      bit_cnt <= bit_cnt_d;
      tx_sr   <= tx_sr_d;
      rx_sr   <= rx_sr_d;
      dr      <= dr_d;
      sck     <= sck_d;
      cs      <= cs_d;
      mosi    <= mosi_d;
      busy    <= busy_d;
      ack     <= ack_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Brief    : Self-checking bench for spi_master (DATA_W=8, CLK_DIV=10).
//             Expected words and ack cycles are queued when a transfer is
//             launched and popped when ack appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ds = 8'h00;
  logic [7:0] dr;
  logic       ack, busy, sck, mosi, cs;
  logic       miso;
  logic [1:0] miso_sel = 2'd0;  // 0 loopback, 1 slave, 2 tied 1, 3 tied 0

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] word;
    int         t;
  } exp_t;
  exp_t exp_q[$];

  // Monitor records (cycle numbers)
  int   rise_t[$];
  logic rise_mosi[$];
  int   cs_falls[$];
  int   ack_t[$];
  logic sck_p = 1'b0;
  logic cs_p = 1'b1;

  // Behavioural mode-0 slave
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_sr = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic [7:0] sl_dr = 8'h00;
  logic       sl_ack = 1'b0;
  logic       sl_miso = 1'b0;

  assign miso = (miso_sel == 2'd0) ? mosi :
                (miso_sel == 2'd1) ? sl_miso :
                (miso_sel == 2'd2);

  spi_master #(.DATA_W(8), .CLK_DIV(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ds    (ds),
    .dr    (dr),
    .ack   (ack),
    .busy  (busy),
    .sck   (sck),
    .mosi  (mosi),
    .miso  (miso),
    .cs    (cs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge recorder and slave model, both evaluated away from the active edge
  always @(negedge clk) begin
    if (cs_p && !cs) begin
      cs_falls.push_back(cyc);
      sl_sr   = sl_tx;
      sl_miso = sl_tx[7];
    end
    if (!cs && sck && !sck_p) begin
      rise_t.push_back(cyc);
      rise_mosi.push_back(mosi);
      sl_rx = {sl_rx[6:0], mosi};
    end
    if (!cs && !sck && sck_p) begin
      sl_sr   = {sl_sr[6:0], 1'b0};
      sl_miso = sl_sr[7];
    end
    if (!cs_p && cs) begin
      sl_dr  = sl_rx;
      sl_ack = 1'b1;
    end
    if (ack === 1'b1) ack_t.push_back(cyc);
    sck_p = sck;
    cs_p  = cs;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_records();
    rise_t.delete();
    rise_mosi.delete();
    cs_falls.delete();
    ack_t.delete();
  endtask

  // Pulse start for one edge; returns the accepting cycle E0.
  task automatic launch(input logic [7:0] d, output int e0);
    @(posedge clk); #1;
    clear_records();
    @(negedge clk);
    start = 1'b1;
    ds    = d;
    @(posedge clk); #1;
    e0    = cyc;
    start = 1'b0;
    ds    = ~d;
  endtask

  task automatic wait_ack(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs !== 1'b1)    begin n_err++; $display("FAIL rst_cs: got %b want 1", cs); end
    n_cmp++; if (sck !== 1'b0)   begin n_err++; $display("FAIL rst_sck: got %b want 0", sck); end
    n_cmp++; if (mosi !== 1'b0)  begin n_err++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 1'b0)   begin n_err++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_cmp++; if (dr !== 8'h00)   begin n_err++; $display("FAIL rst_dr: got %h want 00", dr); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback();
    int   e0;
    bit   ok;
    exp_t e;
    logic [7:0] d;
    d = 8'hA5;
    miso_sel = 2'd0;
    launch(d, e0);
    exp_q.push_back('{word: d, t: e0 + 170});
    n_cmp++; if (cs !== 1'b0)   begin n_err++; $display("FAIL lb_cs_low: got %b want 0", cs); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lb_busy: got %b want 1", busy); end
    n_cmp++; if (mosi !== 1'b1) begin n_err++; $display("FAIL lb_mosi_msb: got %b want 1", mosi); end
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL lb_ack_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL lb_dr: got %h want %h", dr, e.word); end
    n_cmp++; if (cyc !== e.t)   begin n_err++; $display("FAIL lb_ack_time: got %0d want %0d", cyc - e0, e.t - e0); end
    n_cmp++; if (cs !== 1'b1)   begin n_err++; $display("FAIL lb_cs_at_ack: got %b want 1", cs); end
    @(negedge clk);
    n_cmp++; if (ack !== 1'b0)  begin n_err++; $display("FAIL lb_ack_width: got %b want 0", ack); end
    n_cmp++; if (rise_t.size() != 8) begin n_err++; $display("FAIL lb_rise_count: got %0d want 8", rise_t.size()); end
    for (int k = 0; k < rise_t.size() && k < 8; k++) begin
      n_cmp++;
      if (rise_t[k] !== e0 + 10 + 20 * k) begin
        n_err++; $display("FAIL lb_rise_time[%0d]: got %0d want %0d", k, rise_t[k] - e0, 10 + 20 * k);
      end
      n_cmp++;
      if (rise_mosi[k] !== d[7-k]) begin
        n_err++; $display("FAIL lb_mosi_bit[%0d]: got %b want %b", k, rise_mosi[k], d[7-k]);
      end
    end
  endtask

  task automatic test_slave();
    int   e0;
    bit   ok;
    exp_t e;
    miso_sel = 2'd1;
    sl_tx    = 8'h3C;
    sl_ack   = 1'b0;
    launch(8'hC3, e0);
    exp_q.push_back('{word: 8'h3C, t: e0 + 170});
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL sl_ack_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL sl_master_dr: got %h want %h", dr, e.word); end
    n_cmp++; if (cyc !== e.t)   begin n_err++; $display("FAIL sl_ack_time: got %0d want %0d", cyc - e0, e.t - e0); end
    @(negedge clk);
    n_cmp++; if (sl_dr !== 8'hC3) begin n_err++; $display("FAIL sl_slave_dr: got %h want c3", sl_dr); end
    n_cmp++; if (sl_ack !== 1'b1) begin n_err++; $display("FAIL sl_slave_ack: got %b want 1", sl_ack); end
  endtask

  task automatic test_const_miso();
    int   e0;
    bit   ok;
    exp_t e;
    miso_sel = 2'd2;
    launch(8'h00, e0);
    exp_q.push_back('{word: 8'hFF, t: e0 + 170});
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL c1_ack_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL c1_dr: got %h want %h", dr, e.word); end
    repeat (30) @(negedge clk);
    n_cmp++; if (dr !== 8'hFF) begin n_err++; $display("FAIL c1_dr_hold_idle: got %h want ff", dr); end
    miso_sel = 2'd3;
    launch(8'hFF, e0);
    exp_q.push_back('{word: 8'h00, t: e0 + 170});
    repeat (100) @(negedge clk);
    n_cmp++; if (dr !== 8'hFF) begin n_err++; $display("FAIL c0_dr_hold_busy: got %h want ff", dr); end
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL c0_ack_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL c0_dr: got %h want %h", dr, e.word); end
    n_cmp++; if (cyc !== e.t)   begin n_err++; $display("FAIL c0_ack_time: got %0d want %0d", cyc - e0, e.t - e0); end
  endtask

  task automatic test_ignore_busy();
    int   e0;
    bit   ok;
    exp_t e;
    logic [7:0] d;
    d = 8'h81;
    miso_sel = 2'd0;
    launch(d, e0);
    exp_q.push_back('{word: d, t: e0 + 170});
    repeat (49) @(posedge clk);
    #1;
    start = 1'b1;
    ds    = 8'h7E;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ig_ack_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL ig_dr: got %h want %h", dr, e.word); end
    n_cmp++; if (cyc !== e.t)   begin n_err++; $display("FAIL ig_ack_time: got %0d want %0d", cyc - e0, e.t - e0); end
    @(negedge clk);
    n_cmp++; if (cs !== 1'b1)   begin n_err++; $display("FAIL ig_cs_after: got %b want 1", cs); end
    n_cmp++; if (cs_falls.size() != 1) begin n_err++; $display("FAIL ig_cs_falls: got %0d want 1", cs_falls.size()); end
    for (int k = 0; k < rise_mosi.size() && k < 8; k++) begin
      n_cmp++;
      if (rise_mosi[k] !== d[7-k]) begin
        n_err++; $display("FAIL ig_mosi_bit[%0d]: got %b want %b", k, rise_mosi[k], d[7-k]);
      end
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (ack_t.size() != 1) begin n_err++; $display("FAIL ig_ack_count: got %0d want 1", ack_t.size()); end
  endtask

  task automatic test_reset_mid();
    int   e0;
    bit   ok;
    exp_t e;
    miso_sel = 2'd0;
    launch(8'hF0, e0);
    repeat (74) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_busy_before: got %b want 1", busy); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cs !== 1'b1)   begin n_err++; $display("FAIL rm_cs: got %b want 1", cs); end
    n_cmp++; if (sck !== 1'b0)  begin n_err++; $display("FAIL rm_sck: got %b want 0", sck); end
    n_cmp++; if (mosi !== 1'b0) begin n_err++; $display("FAIL rm_mosi: got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (dr !== 8'h00)  begin n_err++; $display("FAIL rm_dr: got %h want 00", dr); end
    n_cmp++; if (ack !== 1'b0)  begin n_err++; $display("FAIL rm_ack: got %b want 0", ack); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    n_cmp++; if (ack_t.size() != 0) begin n_err++; $display("FAIL rm_spurious_ack: got %0d want 0", ack_t.size()); end
    launch(8'h5A, e0);
    exp_q.push_back('{word: 8'h5A, t: e0 + 170});
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rm_ack_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL rm_dr_after: got %h want %h", dr, e.word); end
    n_cmp++; if (cyc !== e.t)   begin n_err++; $display("FAIL rm_ack_time: got %0d want %0d", cyc - e0, e.t - e0); end
  endtask

  task automatic test_back_to_back();
    int   e0;
    bit   ok;
    exp_t e;
    miso_sel = 2'd0;
    @(posedge clk); #1;
    clear_records();
    @(negedge clk);
    start = 1'b1;
    ds    = 8'h12;
    @(posedge clk); #1;
    e0 = cyc;
    ds = 8'h34;
    exp_q.push_back('{word: 8'h12, t: e0 + 170});
    exp_q.push_back('{word: 8'h34, t: e0 + 341});
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bb_ack1_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL bb_dr1: got %h want %h", dr, e.word); end
    n_cmp++; if (cyc !== e.t)   begin n_err++; $display("FAIL bb_ack1_time: got %0d want %0d", cyc - e0, e.t - e0); end
    @(posedge clk); #1;
    start = 1'b0;
    ds    = 8'h00;
    n_cmp++; if (cs !== 1'b0)   begin n_err++; $display("FAIL bb_cs2_low: got %b want 0", cs); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bb_busy2: got %b want 1", busy); end
    wait_ack(400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bb_ack2_timeout: got no ack want ack"); end
    e = exp_q.pop_front();
    n_cmp++; if (dr !== e.word) begin n_err++; $display("FAIL bb_dr2: got %h want %h", dr, e.word); end
    n_cmp++; if (cyc !== e.t)   begin n_err++; $display("FAIL bb_ack2_time: got %0d want %0d", cyc - e0, e.t - e0); end
    n_cmp++;
    if (cs_falls.size() != 2) begin
      n_err++; $display("FAIL bb_cs_fall_count: got %0d want 2", cs_falls.size());
    end else if (cs_falls[1] - cs_falls[0] != 171) begin
      n_err++; $display("FAIL bb_cs_gap: got %0d want 171", cs_falls[1] - cs_falls[0]);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_const_miso();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Mode-0 SPI initiator that drives `sck`, `cs` and `mosi` toward an `spi_slave` and captures `miso` into a parallel word. It is the controller-side counterpart of the slave in the same SPI subsystem. Its parallel side accepts a word on a `start` strobe and returns the received word with a one-cycle `ack`. `sck` is derived from the system clock by a programmable divider.

## Interface
Parameters:
- `DATA_W`, default 8: bits per transfer, MSB first.
- `CLK_DIV`, default 10: `sck` half-period in `clk` cycles; legal range ≥ 2.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request a transfer; sampled only in IDLE.
- `ds`  in  DATA_W: word to send; latched on the accepting edge.
- `dr`  out  DATA_W: last received word; updated only at transfer end.
- `ack`  out  1: one-cycle pulse when `dr` becomes valid.
- `busy`  out  1: high from the accepting edge until `cs` deasserts.
- `sck`  out  1: serial clock; idles low (CPOL=0).
- `mosi`  out  1: serial data to the slave.
- `miso`  in  1: serial data from the slave.
- `cs`  out  1: chip select, active-low.

## Operation
- All outputs are registered. Single clock domain; `miso` is treated as synchronous to `clk`.
- Reset (async, any time including mid-transfer):
  - cs=1, sck=0, mosi=0, busy=0, ack=0, dr=0.
  - State goes to IDLE; divider counter and bit counter clear.
- States: IDLE → LEAD → XFER → TRAIL → IDLE.
- **IDLE**
  - Outputs: cs=1, sck=0, mosi=0.
  - On `start`=1: latch `ds` into the tx shift register, drive cs=0 and mosi=ds[DATA_W-1], set busy=1, enter LEAD.
- **LEAD**
  - Wait CLK_DIV cycles (setup), then drive sck=1 and enter XFER.
- **XFER**
  - Toggle `sck` every CLK_DIV cycles.
  - Rising edge of `sck` (0→1): sample `miso` into the rx shift register LSB, shifting left, on the same `clk` edge that sets sck=1.
  - Falling edge of `sck` (1→0), except the last: shift tx and drive mosi with the next bit.
  - Exit after the DATA_W-th falling edge, with sck=0 and mosi holding bit 0; enter TRAIL.
- **TRAIL**
  - Wait CLK_DIV cycles, then drive cs=1, busy=0, mosi=0, dr=rx shift register, ack=1; return to IDLE.
- `start` while busy=1 is ignored; there is no queueing.
- `ds` changes after the accepting edge do not affect the transfer in progress.
- `dr` holds its value between transfers.

## Timing
- E0 is the `clk` edge that samples `start`=1 in IDLE.
- cs=0, busy=1, mosi=ds[MSB] after E0.
- `sck` rises at E0 + (2k+1)·CLK_DIV, for k = 0..DATA_W-1; `miso` is captured at these edges.
- `sck` falls at E0 + (2k+2)·CLK_DIV.
- `mosi` changes to ds[DATA_W-2-k] at E0 + (2k+2)·CLK_DIV, for k = 0..DATA_W-2.
- Last `sck` fall is at E0 + 2·DATA_W·CLK_DIV.
- cs=1, busy=0, ack=1, `dr` valid at E0 + (2·DATA_W+1)·CLK_DIV. With defaults that is E0+170.
- `ack` is high for exactly one cycle.
- Back-to-back transfers: a `start` held during the `ack` cycle is accepted on the next edge. `cs` is therefore high for a minimum of 1 cycle between transfers.
- `sck` duty cycle is exactly 50%, period 2·CLK_DIV; there are no glitches on cs, sck or mosi.

## Test plan
All scenarios use DATA_W=8, CLK_DIV=10.

1. Loopback (`miso`=`mosi`), ds=0xA5, pulse start:
   - 8 `sck` rising edges, at E0+10 and then every 20 cycles.
   - mosi sequence 1,0,1,0,0,1,0,1.
   - dr=0xA5 and ack=1 for one cycle at E0+170; cs high in the same cycle.
2. Slave model (`spi_slave`, mode 0) with ds=0xC3 on the master side and 0x3C loaded in the slave:
   - Master dr=0x3C.
   - Slave dr=0xC3 and slave ack asserted.
3. `miso` tied 1, then tied 0:
   - dr=0xFF, then dr=0x00.
   - `dr` unchanged between transfers.
4. Start ignored while busy: ds=0x81, then pulse start with ds=0x7E at E0+50:
   - Only one transfer; mosi reflects 0x81; no second cs low before E0+171.
5. rst_n low at E0+75:
   - Immediately cs=1, sck=0, mosi=0, busy=0, dr=0x00, no ack.
   - After release, a new transfer with ds=0x5A completes normally.
6. Back-to-back: start held high continuously with ds=0x12 then 0x34:
   - Second cs falls 1 cycle after the first ack.
   - ack pulses at E0+170 and E0+341.
